// File: rtl/keypad_timer_pkg.sv
// Shared constants and types for the keypad timer: digit width, BCD limits,
// mode encoding and the M:SS digit bundle.
package keypad_timer_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t BCD_MAX       = digit_t'(9);
  localparam digit_t SEC_TENS_WRAP = digit_t'(5);

  typedef enum logic {
    MODE_ENTRY = 1'b0,
    MODE_COUNT = 1'b1
  } mode_e;

  // Three-digit M:SS value as presented to the display
  typedef struct packed {
    digit_t min;
    digit_t sec_tens;
    digit_t sec_ones;
  } mss_t;

  // True for key codes 0..9
  function automatic logic is_bcd(input digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/keypad_timer_bcd_down_digit.sv
// One decimal digit register with parallel load and wrap-around decrement.
// Ports:
//   clk, clear      - clock, synchronous active-high reset
//   load, load_val  - parallel load (priority over dec)
//   dec             - decrement request; 0 wraps to wrap_val
//   wrap_val        - value taken when decrementing from 0
//   value           - current digit
//   borrow_out      - dec while value is 0 (ripples to the next digit)
module bcd_down_digit
  import keypad_timer_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec,
  input  logic [DIGIT_W-1:0] wrap_val,
  output logic [DIGIT_W-1:0] value,
  output logic               borrow_out
);

  logic at_zero;

  assign at_zero    = (value == '0);
  assign borrow_out = dec & at_zero;

  // Digit register: load beats decrement
  always_ff @(posedge clk) begin
    if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec) begin
      value <= at_zero ? wrap_val : value - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/keypad_timer.sv
// Keypad timer: shifts keyed BCD digits into an M:SS register in entry mode
// and counts it down once per pgt_1Hz rising edge in count mode.
// Ports:
//   clk, clear   - clock, synchronous active-high reset
//   D, loadn     - BCD key code and active-low key strobe from the encoder
//   pgt_1Hz      - pulse train; only its rising edge advances the digits
//   count_mode   - 0 entry, 1 countdown
//   min, sec_tens, sec_ones - display digits
//   zero         - all digits 0 (combinational from the digit registers)
//   done         - one-cycle pulse after a countdown lands on 0:00
module keypad_timer
  import keypad_timer_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] D,
  input  logic               loadn,
  input  logic               pgt_1Hz,
  input  logic               count_mode,
  output logic [DIGIT_W-1:0] min,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               zero,
  output logic               done
);

  logic  pgt_q;
  logic  tick;
  logic  dec_q;
  mode_e mode;
  logic  entry_load;
  logic  count_dec;
  logic  ones_borrow;
  logic  tens_borrow;
  logic  unused_min_borrow;
  mss_t  digits;

  assign mode = mode_e'(count_mode);
  assign tick = pgt_1Hz & ~pgt_q;

  // Entry shifts only on a strobed valid key; countdown stops at 0:00
  assign entry_load = tick && (mode == MODE_ENTRY) && !loadn && is_bcd(D);
  assign count_dec  = tick && (mode == MODE_COUNT) && !zero;

  bcd_down_digit u_ones (
    .clk        (clk),
    .clear      (clear),
    .load       (entry_load),
    .load_val   (D),
    .dec        (count_dec),
    .wrap_val   (BCD_MAX),
    .value      (digits.sec_ones),
    .borrow_out (ones_borrow)
  );

  bcd_down_digit u_tens (
    .clk        (clk),
    .clear      (clear),
    .load       (entry_load),
    .load_val   (digits.sec_ones),
    .dec        (ones_borrow),
    .wrap_val   (SEC_TENS_WRAP),
    .value      (digits.sec_tens),
    .borrow_out (tens_borrow)
  );

  // Minutes never borrow out: count_dec is blocked at 0:00
  bcd_down_digit u_min (
    .clk        (clk),
    .clear      (clear),
    .load       (entry_load),
    .load_val   (digits.sec_tens),
    .dec        (tens_borrow),
    .wrap_val   (BCD_MAX),
    .value      (digits.min),
    .borrow_out (unused_min_borrow)
  );

  assign min      = digits.min;
  assign sec_tens = digits.sec_tens;
  assign sec_ones = digits.sec_ones;
  assign zero     = (digits == '0);

  // Edge detector and done pulse; done fires the cycle after the digits
  // first show 0:00 as the result of a decrement
  always_ff @(posedge clk) begin
    if (clear) begin
      pgt_q <= 1'b0;
      dec_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      pgt_q <= pgt_1Hz;
      dec_q <= count_dec;
      done  <= dec_q & zero;
    end
  end

endmodule

// File: tb/tb_keypad_timer.sv
// Self-checking bench for keypad_timer against a digit-level reference model.
module tb_keypad_timer;

  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;
  logic       count_mode;
  logic [3:0] min;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       zero;
  logic       done;

  int checks = 0;
  int errors = 0;
  int em, et, eo;

  always #5 clk = ~clk;

  keypad_timer dut (
    .clk        (clk),
    .clear      (clear),
    .D          (D),
    .loadn      (loadn),
    .pgt_1Hz    (pgt_1Hz),
    .count_mode (count_mode),
    .min        (min),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .zero       (zero),
    .done       (done)
  );

  // Reference: keypad shift or M:SS countdown with 0:00 floor
  task automatic model_step(input bit mode, input logic [3:0] d, input logic ld,
                            output bit exp_done);
    exp_done = 1'b0;
    if (!mode) begin
      if (!ld && d <= 4'd9) begin
        em = et; et = eo; eo = int'(d);
      end
    end else if (em + et + eo != 0) begin
      if (eo > 0) eo--;
      else begin
        eo = 9;
        if (et > 0) et--;
        else begin et = 5; em--; end
      end
      exp_done = (em + et + eo == 0);
    end
  endtask

  // One pgt_1Hz rise with the given mode/key; counts done pulses afterwards
  task automatic pulse(input bit mode, input logic [3:0] d, input logic ld,
                       output int dones, output bit exp_done);
    @(negedge clk);
    count_mode = mode; D = d; loadn = ld; pgt_1Hz = 1'b1;
    model_step(mode, d, ld, exp_done);
    dones = 0;
    @(negedge clk); pgt_1Hz = 1'b0; loadn = 1'b1;
    if (done) dones++;
    @(negedge clk); if (done) dones++;
    @(negedge clk); if (done) dones++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear = 1'b1; pgt_1Hz = 1'b0; loadn = 1'b1; count_mode = 1'b0; D = '0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;
    em = 0; et = 0; eo = 0;
  endtask

  task automatic key(input logic [3:0] d);
    int dn; bit ed;
    pulse(1'b0, d, 1'b0, dn, ed);
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear = 1'b1; pgt_1Hz = 1'b1; loadn = 1'b0; D = 4'd7; count_mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({min, sec_tens, sec_ones} !== 12'h000) begin
      errors++; $display("FAIL reset_digits got %h%h%h want 000", min, sec_tens, sec_ones);
    end
    checks++;
    if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    // pgt_1Hz already high at release gives a tick on the first cycle
    clear = 1'b0;
    @(negedge clk);
    pgt_1Hz = 1'b0; loadn = 1'b1;
    checks++;
    if ({min, sec_tens, sec_ones} !== 12'h007) begin
      errors++; $display("FAIL release_tick got %h%h%h want 007", min, sec_tens, sec_ones);
    end
  endtask

  task automatic test_entry();
    do_reset();
    key(4'd1); key(4'd3); key(4'd0);
    checks++;
    if (min !== 4'(em) || sec_tens !== 4'(et) || sec_ones !== 4'(eo) || em != 1 || et != 3 || eo != 0) begin
      errors++; $display("FAIL entry_130 got %0d:%0d%0d want 1:30", min, sec_tens, sec_ones);
    end
    checks++;
    if (zero !== 1'b0) begin errors++; $display("FAIL entry_zero got %b want 0", zero); end
  endtask

  task automatic test_countdown();
    int dn; bit ed; int bad;
    do_reset();
    key(4'd1); key(4'd0); key(4'd0);
    pulse(1'b1, 4'd0, 1'b1, dn, ed);
    checks++;
    if ({min, sec_tens, sec_ones} !== 12'h059) begin
      errors++; $display("FAIL borrow_059 got %0d:%0d%0d want 0:59", min, sec_tens, sec_ones);
    end
    bad = 0;
    for (int i = 0; i < 59; i++) begin
      pulse(1'b1, 4'(i % 16), 1'(i % 2), dn, ed);
      if (min !== 4'(em) || sec_tens !== 4'(et) || sec_ones !== 4'(eo) || dn != int'(ed)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL countdown_steps got %0d bad steps want 0", bad); end
    checks++;
    if ({min, sec_tens, sec_ones, zero} !== 13'h0001 || dn != 1) begin
      errors++; $display("FAIL done_pulse got %0d:%0d%0d zero=%b dones=%0d want 0:00 zero=1 dones=1",
                         min, sec_tens, sec_ones, zero, dn);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 4'd0, 1'b1, dn, ed);
      if ({min, sec_tens, sec_ones} !== 12'h000 || dn != 0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_at_zero got %0d bad want 0", bad); end
  endtask

  task automatic test_invalid();
    int dn; bit ed;
    do_reset();
    key(4'd4); key(4'd2);
    pulse(1'b0, 4'd12, 1'b0, dn, ed);
    pulse(1'b0, 4'd5, 1'b1, dn, ed);
    checks++;
    if ({min, sec_tens, sec_ones} !== 12'h042) begin
      errors++; $display("FAIL invalid_hold got %0d:%0d%0d want 0:42", min, sec_tens, sec_ones);
    end
  endtask

  task automatic test_single_tick();
    do_reset();
    key(4'd1); key(4'd0);
    @(negedge clk);
    count_mode = 1'b1; pgt_1Hz = 1'b1;
    repeat (50) @(negedge clk);
    pgt_1Hz = 1'b0;
    @(negedge clk);
    checks++;
    if ({min, sec_tens, sec_ones} !== 12'h009) begin
      errors++; $display("FAIL single_tick got %0d:%0d%0d want 0:09", min, sec_tens, sec_ones);
    end
  endtask

  task automatic test_reset_mid();
    int dn; bit ed;
    do_reset();
    key(4'd5);
    pulse(1'b1, 4'd0, 1'b1, dn, ed);
    pulse(1'b1, 4'd0, 1'b1, dn, ed);
    checks++;
    if ({min, sec_tens, sec_ones} !== 12'h003) begin
      errors++; $display("FAIL mid_003 got %0d:%0d%0d want 0:03", min, sec_tens, sec_ones);
    end
    @(negedge clk);
    pgt_1Hz = 1'b1; clear = 1'b1;
    @(negedge clk);
    dn = int'(done);
    @(negedge clk);
    dn += int'(done);
    checks++;
    if ({min, sec_tens, sec_ones} !== 12'h000 || dn != 0) begin
      errors++; $display("FAIL reset_mid got %0d:%0d%0d dones=%0d want 0:00 dones=0",
                         min, sec_tens, sec_ones, dn);
    end
    clear = 1'b0; pgt_1Hz = 1'b0;
    @(negedge clk);
    em = 0; et = 0; eo = 0;
  endtask

  task automatic test_overrange();
    int dn; bit ed;
    do_reset();
    key(4'd9); key(4'd0);
    pulse(1'b1, 4'd0, 1'b1, dn, ed);
    checks++;
    if ({min, sec_tens, sec_ones} !== 12'h089) begin
      errors++; $display("FAIL overrange_089 got %0d:%0d%0d want 0:89", min, sec_tens, sec_ones);
    end
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    checks++;
    if ({min, sec_tens, sec_ones} !== 12'h234) begin
      errors++; $display("FAIL full_shift got %0d:%0d%0d want 2:34", min, sec_tens, sec_ones);
    end
  endtask

  // Mode flips on the same edge as the tick take the new mode's action
  task automatic test_mode_switch();
    int dn; bit ed;
    do_reset();
    key(4'd2); key(4'd0);
    pulse(1'b1, 4'd7, 1'b0, dn, ed);
    checks++;
    if ({min, sec_tens, sec_ones} !== 12'h019) begin
      errors++; $display("FAIL switch_to_count got %0d:%0d%0d want 0:19", min, sec_tens, sec_ones);
    end
    pulse(1'b0, 4'd6, 1'b0, dn, ed);
    checks++;
    if ({min, sec_tens, sec_ones} !== 12'h196) begin
      errors++; $display("FAIL switch_to_entry got %0d:%0d%0d want 1:96", min, sec_tens, sec_ones);
    end
  endtask

  task automatic test_random();
    int dn; bit ed; bit m; logic [3:0] d; logic ld;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      m  = ($urandom_range(0, 2) == 0);
      d  = 4'($urandom_range(0, 15));
      ld = ($urandom_range(0, 3) == 0);
      pulse(m, d, ld, dn, ed);
      checks++;
      if (min !== 4'(em) || sec_tens !== 4'(et) || sec_ones !== 4'(eo) ||
          zero !== (em + et + eo == 0) || dn != int'(ed)) begin
        errors++;
        $display("FAIL random_%0d got %0d:%0d%0d z=%b dones=%0d want %0d:%0d%0d dones=%0d",
                 i, min, sec_tens, sec_ones, zero, dn, em, et, eo, int'(ed));
      end
    end
  endtask

  initial begin
    clear = 1'b1; D = '0; loadn = 1'b1; pgt_1Hz = 1'b0; count_mode = 1'b0;
    test_reset();
    test_entry();
    test_countdown();
    test_invalid();
    test_single_tick();
    test_reset_mid();
    test_overrange();
    test_mode_switch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
